// File: rtl/cam_dual_window_capture.sv
// Camera pixel-stream capture: decodes vsync/href/d into x/y and writes a display
// window every frame and a calculation window on one frame out of FRAME_DIV.
module cam_dual_window_capture #(
    parameter int DW            = 3,
    parameter int BYTES_PER_PIX = 2,
    parameter int DISP_X0       = 270,
    parameter int DISP_Y0       = 190,
    parameter int DISP_W        = 100,
    parameter int DISP_H        = 100,
    parameter int DISP_AW       = 16,
    parameter int CALC_X0       = 318,
    parameter int CALC_Y0       = 238,
    parameter int CALC_W        = 79,
    parameter int CALC_H        = 16,
    parameter int CALC_AW       = 11,
    parameter int FRAME_DIV     = 30,
    parameter int PROBE_IDX     = 14
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic                 href,
    input  logic [DW-1:0]        d,
    output logic [DW-1:0]        disp_data,
    output logic [DISP_AW-1:0]   disp_addr,
    output logic                 disp_wren,
    output logic [DW-1:0]        calc_data,
    output logic [CALC_AW-1:0]   calc_addr,
    output logic                 calc_wren,
    output logic                 calc_done,
    output logic [((FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1)-1:0] frame_cnt,
    output logic [DW-1:0]        probe
);

    localparam int FCW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int PW    = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int X_END = (DISP_X0 + DISP_W > CALC_X0 + CALC_W) ? DISP_X0 + DISP_W : CALC_X0 + CALC_W;
    localparam int Y_END = (DISP_Y0 + DISP_H > CALC_Y0 + CALC_H) ? DISP_Y0 + DISP_H : CALC_Y0 + CALC_H;
    // Counters saturate at all-ones, which is always beyond both windows.
    localparam int XW    = $clog2(X_END + 1);
    localparam int YW    = $clog2(Y_END + 1);

    localparam logic [XW-1:0]      DX_LO   = XW'(DISP_X0);
    localparam logic [XW-1:0]      DX_HI   = XW'(DISP_X0 + DISP_W - 1);
    localparam logic [YW-1:0]      DY_LO   = YW'(DISP_Y0);
    localparam logic [YW-1:0]      DY_HI   = YW'(DISP_Y0 + DISP_H - 1);
    localparam logic [XW-1:0]      CX_LO   = XW'(CALC_X0);
    localparam logic [XW-1:0]      CX_HI   = XW'(CALC_X0 + CALC_W - 1);
    localparam logic [YW-1:0]      CY_LO   = YW'(CALC_Y0);
    localparam logic [YW-1:0]      CY_HI   = YW'(CALC_Y0 + CALC_H - 1);
    localparam logic [DISP_AW:0]   DISP_NV = (DISP_AW + 1)'(DISP_W * DISP_H);
    localparam logic [CALC_AW:0]   CALC_NV = (CALC_AW + 1)'(CALC_W * CALC_H);
    localparam logic [CALC_AW:0]   CALC_LV = (CALC_AW + 1)'(CALC_W * CALC_H - 1);
    localparam logic [CALC_AW:0]   PROBE_V = (CALC_AW + 1)'(PROBE_IDX);
    localparam logic [PW-1:0]      PH_LAST = PW'(BYTES_PER_PIX - 1);
    localparam logic [FCW-1:0]     FC_LAST = FCW'(FRAME_DIV - 1);

    logic            vsync_q, href_q;
    logic [PW-1:0]   phase;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    // One extra bit so a pointer can sit at W*H even when W*H == 2**AW.
    logic [DISP_AW:0] dptr;
    logic [CALC_AW:0] cptr;
    logic            calc_last;

    logic frame_start, line_end, pix_stb, pick, disp_hit, calc_hit;

    assign frame_start = vsync & ~vsync_q;
    assign line_end    = href_q & ~href;
    assign pix_stb     = href & ~vsync & (phase == PH_LAST);
    assign pick        = (frame_cnt == FC_LAST);
    assign disp_hit    = pix_stb && (x >= DX_LO) && (x <= DX_HI) && (y >= DY_LO) && (y <= DY_HI);
    assign calc_hit    = pix_stb && (x >= CX_LO) && (x <= CX_HI) && (y >= CY_LO) && (y <= CY_HI);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            phase     <= '0;
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else begin
            // NOTE: all state updates use <= so every branch sees the pre-edge values.
            vsync_q <= vsync;
            href_q  <= href;

            if (href && !vsync)
                phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
            else
                phase <= '0;

            if (vsync) begin
                x <= '0;
                y <= '0;
            end else if (pix_stb) begin
                if (x != '1) x <= x + XW'(1);
            end else if (line_end) begin
                x <= '0;
                if (x != '0 && y != '1) y <= y + YW'(1);
            end

            if (frame_start)
                frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FCW'(1);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            dptr      <= '0;
            disp_addr <= '0;
            disp_data <= '0;
            disp_wren <= 1'b0;
        end else begin
            disp_wren <= 1'b0;
            if (frame_start || y > DY_HI) begin
                dptr <= '0;
            end else if (disp_hit && dptr != DISP_NV) begin
                disp_addr <= dptr[DISP_AW-1:0];
                disp_data <= d;
                disp_wren <= 1'b1;
                dptr      <= dptr + (DISP_AW + 1)'(1);
            end
        end
    end

    // Unpicked frames still walk cptr so the index/pixel relation is identical every frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cptr      <= '0;
            calc_addr <= '0;
            calc_data <= '0;
            calc_wren <= 1'b0;
            calc_last <= 1'b0;
            calc_done <= 1'b0;
            probe     <= '0;
        end else begin
            calc_wren <= 1'b0;
            calc_last <= 1'b0;
            calc_done <= calc_last;
            if (frame_start || y > CY_HI) begin
                cptr <= '0;
            end else if (calc_hit && cptr != CALC_NV) begin
                calc_addr <= cptr[CALC_AW-1:0];
                calc_data <= d;
                calc_wren <= pick;
                calc_last <= pick && (cptr == CALC_LV);
                if (pick && cptr == PROBE_V) probe <= d;
                cptr      <= cptr + (CALC_AW + 1)'(1);
            end
        end
    end

endmodule

// File: doc/cam_dual_window_capture.md
Name: cam_dual_window_capture

Overview:
- Parametrised successor to the left-camera capture stage.
- Decodes a camera pixel stream (vsync/href/d, 1 or 2 bytes per pixel) into x/y coordinates and writes two rectangular windows into two RAM write ports: a display window every frame and a calculation window on one frame out of FRAME_DIV.
- Runs entirely in the camera pixel clock domain with a proper reset, vsync edge detection, a window-complete pulse and a probe capture.
- Sits between the camera pins and the display and disparity-calculation buffers.

Parameters:
DW, 3, pixel data width on d and both data outputs
BYTES_PER_PIX, 2, pclk cycles per pixel while href=1 (legal: 1 or 2)
DISP_X0, 270, display window first column
DISP_Y0, 190, display window first row
DISP_W, 100, display window width in pixels
DISP_H, 100, display window height in lines
DISP_AW, 16, display address width (DISP_W*DISP_H <= 2**DISP_AW)
CALC_X0, 318, calc window first column
CALC_Y0, 238, calc window first row
CALC_W, 79, calc window width
CALC_H, 16, calc window height
CALC_AW, 11, calc address width (CALC_W*CALC_H <= 2**CALC_AW)
FRAME_DIV, 30, calc window written on one frame out of FRAME_DIV (>=1)
PROBE_IDX, 14, calc-window linear index whose pixel is latched on probe

Ports:
pclk  in  1  camera pixel clock; sole clock, also drives both RAM write clocks
rst_n  in  1  asynchronous active-low reset
vsync  in  1  frame sync, high during vertical blanking
href  in  1  line valid
d  in  DW  camera pixel data
disp_data  out  DW  display RAM write data
disp_addr  out  DISP_AW  display RAM write address
disp_wren  out  1  display RAM write enable
calc_data  out  DW  calc RAM write data
calc_addr  out  CALC_AW  calc RAM write address
calc_wren  out  1  calc RAM write enable
calc_done  out  1  one-cycle pulse when a picked frame's calc window is fully written
frame_cnt  out  max(1,$clog2(FRAME_DIV))  current frame index modulo FRAME_DIV
probe  out  DW  pixel value written at calc index PROBE_IDX in the last picked frame

Behaviour:
- Reset (async, rst_n=0): every output, x, y, byte phase, both write pointers, frame_cnt, and registered vsync/href copies are set to 0.
- Edge detection: vsync_q and href_q are registered copies.
  - frame_start = vsync & ~vsync_q.
  - line_end = href_q & ~href.
- frame_cnt: increments on frame_start; wraps FRAME_DIV-1 -> 0. pick = (frame_cnt == FRAME_DIV-1). For FRAME_DIV=1, pick is always 1.
- Byte phase: advances modulo BYTES_PER_PIX each cycle with href=1 and vsync=0; forced to 0 when href=0.
- Pixel strobe: pix_stb = href & ~vsync & (phase == BYTES_PER_PIX-1). The d sampled in the strobe cycle is the pixel value.
- Coordinates:
  - vsync=1: x=0, y=0.
  - pix_stb: x+1.
  - line_end: x=0; y+1 only if x!=0 (empty lines are not counted).
  - The pixel coordinate is the x/y value during its strobe cycle.
  - x and y saturate at their maximum and do not wrap.
- Display write: on pix_stb with DISP_X0<=x<=DISP_X0+DISP_W-1 and DISP_Y0<=y<=DISP_Y0+DISP_H-1:
  - next cycle: disp_addr=dptr, disp_data=d, disp_wren=1; then dptr+1.
  - Latency is 1 cycle from the strobe.
- Calc write: same rule with the CALC window and cptr. calc_wren = pick; cptr advances whether or not the frame is picked.
- Between writes: the wren outputs are 0; addr and data hold their last values.
- Pointer clear: dptr/cptr clear to 0 on frame_start, and whenever y is past their window's last row.
- Pointer saturation: a pointer never exceeds W*H. At W*H, further hits are suppressed (no wren).
- calc_done: 1-cycle pulse in the cycle after the write of calc index CALC_W*CALC_H-1 in a picked frame. It is never asserted for an unpicked or truncated frame.
- probe: updated with d when a picked calc write uses index PROBE_IDX. Held otherwise.
- vsync=1 together with href=1: vsync dominates; no strobe and no writes.
- vsync rising mid-window: pointers clear, the partial window is abandoned, no calc_done, and frame_cnt still advances.
- rst_n asserted mid-write: all outputs drop to 0 immediately (async), including any wren in progress.

Test Plan:
- Reset: rst_n=0 with random inputs -> all outputs 0; after release with vsync/href idle, all outputs stay 0.
- Display window, small params (DISP_X0=2, DISP_Y0=1, DISP_W=3, DISP_H=2, BYTES_PER_PIX=2, 8-px lines, d=pixel x) -> exactly 6 disp_wren pulses, addr 0..5, data 2,3,4,2,3,4, each 1 cycle after its strobe.
- Frame decimation, FRAME_DIV=3, 4 frames -> calc_wren only in the frame after the 2nd vsync rise; frame_cnt sequence 1,2,0,1; calc_done exactly once; cptr/addr restart at 0 every frame.
- Probe, PROBE_IDX=4, picked frame with d = calc index mod 8 -> probe=4 after the frame and unchanged through unpicked frames.
- Truncation: vsync rises after 3 of 6 calc pixels in a picked frame -> no calc_done; the next picked frame starts writing at calc_addr 0.
- BYTES_PER_PIX=1, plus vsync&href both high -> a write on every in-window href cycle; no writes while vsync=1.
